// File: rtl/frog_input_controller.sv
// frog_input_controller
//   Turns four debounced switch levels into single-cycle, mutually exclusive
//   move pulses with hold-to-repeat. Holding all four switches for
//   START_HOLD_CYCLES produces a one-shot start pulse instead.
// Ports:
//   i_Clk          pixel clock
//   i_Rst_L        async active-low reset
//   i_Switches     [0]=Up [1]=Down [2]=Left [3]=Right, 1 = pressed
//   i_Game_Active  high while a game runs; gates move pulses, blocks start
//   o_Up/o_Down/o_Left/o_Right  one-cycle move pulses
//   o_Start        one-cycle start pulse
//   o_Held_Dir     owner of the repeat timer (0=U 1=D 2=L 3=R), 0 when none
module frog_input_controller #(
  parameter int START_HOLD_CYCLES   = 12500000,
  parameter int REPEAT_DELAY_CYCLES = 6250000,
  parameter int REPEAT_RATE_CYCLES  = 3125000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [3:0] i_Switches,
  input  logic       i_Game_Active,
  output logic       o_Up,
  output logic       o_Down,
  output logic       o_Left,
  output logic       o_Right,
  output logic       o_Start,
  output logic [1:0] o_Held_Dir
);

  localparam int MAX_AB = (START_HOLD_CYCLES > REPEAT_DELAY_CYCLES) ?
                          START_HOLD_CYCLES : REPEAT_DELAY_CYCLES;
  localparam int MAX_P  = (MAX_AB > REPEAT_RATE_CYCLES) ? MAX_AB : REPEAT_RATE_CYCLES;
  localparam int CW     = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] L_START = CW'(START_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] L_DELAY = CW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CW-1:0] L_RATE  = CW'(REPEAT_RATE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HELD, COMBO, LOCKOUT} state_t;

  state_t        r_State;
  logic [CW-1:0] r_Cnt;
  logic [3:0]    r_Prev;
  logic [3:0]    r_Moves;   // {Right, Left, Down, Up}
  logic          r_Start;
  logic [1:0]    r_Owner;

  logic [3:0]    w_Rise;
  logic [1:0]    w_Sel;
  logic [3:0]    w_Sel_Oh;
  logic [3:0]    w_Own_Oh;
  logic          w_All;
  logic          w_None;

  assign w_Rise   = i_Switches & ~r_Prev;
  assign w_All    = (i_Switches == 4'b1111);
  assign w_None   = (i_Switches == 4'b0000);
  assign w_Own_Oh = 4'b0001 << r_Owner;

  // Newly pressed bits resolved by priority Up > Down > Left > Right.
  always_comb begin
    w_Sel    = 2'd0;
    w_Sel_Oh = 4'b0000;
    if (w_Rise[0])      begin w_Sel = 2'd0; w_Sel_Oh = 4'b0001; end
    else if (w_Rise[1]) begin w_Sel = 2'd1; w_Sel_Oh = 4'b0010; end
    else if (w_Rise[2]) begin w_Sel = 2'd2; w_Sel_Oh = 4'b0100; end
    else if (w_Rise[3]) begin w_Sel = 2'd3; w_Sel_Oh = 4'b1000; end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_State <= LOCKOUT;
      r_Cnt   <= '0;
      r_Prev  <= 4'b1111;   // a switch held through reset never looks "new"
      r_Moves <= 4'b0000;
      r_Start <= 1'b0;
      r_Owner <= 2'd0;
    end else begin
      r_Prev  <= i_Switches;
      r_Moves <= 4'b0000;
      r_Start <= 1'b0;
      case (r_State)
        IDLE: begin
          if (w_All) begin
            r_State <= COMBO;
            r_Cnt   <= L_START;
          end else if (|w_Rise) begin
            r_State <= HELD;
            r_Cnt   <= L_DELAY;
            r_Owner <= w_Sel;
            r_Moves <= w_Sel_Oh & {4{i_Game_Active}};
          end
        end
        HELD: begin
          if (w_All) begin
            r_State <= COMBO;
            r_Cnt   <= L_START;
            r_Owner <= 2'd0;
          end else if (i_Switches[r_Owner]) begin
            // Other presses are ignored while the owner stays down.
            if (r_Cnt == '0) begin
              r_Cnt   <= L_RATE;
              r_Moves <= w_Own_Oh & {4{i_Game_Active}};
            end else begin
              r_Cnt <= r_Cnt - 1'b1;
            end
          end else begin
            r_State <= w_None ? IDLE : LOCKOUT;
            r_Owner <= 2'd0;
          end
        end
        COMBO: begin
          if (!w_All) begin
            r_State <= LOCKOUT;
          end else if (r_Cnt == '0) begin
            r_State <= LOCKOUT;
            r_Start <= ~i_Game_Active;
          end else begin
            r_Cnt <= r_Cnt - 1'b1;
          end
        end
        LOCKOUT: begin
          if (w_None) r_State <= IDLE;
        end
        default: r_State <= LOCKOUT;
      endcase
    end
  end

  assign o_Up       = r_Moves[0];
  assign o_Down     = r_Moves[1];
  assign o_Left     = r_Moves[2];
  assign o_Right    = r_Moves[3];
  assign o_Start    = r_Start;
  assign o_Held_Dir = r_Owner;

endmodule
